// File: rtl/mtncl_net_pkg.sv
// Shared constants and types for the binary gate-network front-ends.
package mtncl_net_pkg;

    localparam int unsigned N_BITS = 49;
    localparam int unsigned N_OUT  = 2;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned IDX_W  = $clog2(N_BITS);

    typedef enum logic [1:0] {
        StLoad,
        StEval,
        StHold
    } loader_state_e;

endpackage

// File: rtl/pix_binarizer.sv
// Pure threshold compare of one grayscale pixel: bit = (pix >= THRESH).
module pix_binarizer #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic [PIX_W-1:0] pix_data_i,
    output logic             pix_bit_o
);

    localparam logic [PIX_W-1:0] Thresh = PIX_W'(THRESH);

    assign pix_bit_o = (pix_data_i >= Thresh);

endmodule

// File: rtl/binary_frame_loader.sv
// Collects a binarised pixel frame into the network input vector, lets the network
// settle for EVAL_CYCLES, then offers the captured output over a valid/ready handshake.
module binary_frame_loader
    import mtncl_net_pkg::*;
#(
    parameter int unsigned THRESH      = 128,
    parameter int unsigned EVAL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [PIX_W-1:0]  pix_data_i,
    input  logic              pix_last_i,
    output logic [N_BITS-1:0] net_in_o,
    input  logic [N_OUT-1:0]  net_out_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [N_OUT-1:0]  res_bits_o,
    output logic              res_err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N_BITS - 1);
    localparam logic [3:0]       EvalLoad = 4'(EVAL_CYCLES - 1);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        eval_cnt_q, eval_cnt_d;
    logic [N_BITS-1:0] net_in_q, net_in_d;
    logic              err_q, err_d;
    logic              res_valid_q, res_valid_d;
    logic [N_OUT-1:0]  res_bits_q, res_bits_d;
    logic              res_err_q, res_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic pix_bit;
    logic pix_accept;
    logic at_last_idx;

    pix_binarizer #(
        .PIX_W  (PIX_W),
        .THRESH (THRESH)
    ) u_binarizer (
        .pix_data_i (pix_data_i),
        .pix_bit_o  (pix_bit)
    );

    assign pix_ready_o = (state_q == StLoad);
    assign pix_accept  = pix_valid_i & pix_ready_o;
    assign at_last_idx = (idx_q == LastIdx);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        eval_cnt_d  = eval_cnt_q;
        net_in_d    = net_in_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_bits_d  = res_bits_q;
        res_err_d   = res_err_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StLoad: begin
                if (pix_accept) begin
                    net_in_d[idx_q] = pix_bit;
                    if (pix_last_i || at_last_idx) begin
                        // Only pix_last landing exactly on the final index is a clean frame.
                        err_d      = ~(pix_last_i & at_last_idx);
                        idx_d      = '0;
                        eval_cnt_d = EvalLoad;
                        state_d    = StEval;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StEval: begin
                if (eval_cnt_q == 4'd0) begin
                    res_bits_d  = net_out_i;
                    res_err_d   = err_q;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    eval_cnt_d = eval_cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    net_in_d    = '0;
                    idx_d       = '0;
                    err_d       = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            idx_q       <= '0;
            eval_cnt_q  <= '0;
            net_in_q    <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_bits_q  <= '0;
            res_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            eval_cnt_q  <= eval_cnt_d;
            net_in_q    <= net_in_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_bits_q  <= res_bits_d;
            res_err_q   <= res_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign net_in_o    = net_in_q;
    assign res_valid_o = res_valid_q;
    assign res_bits_o  = res_bits_q;
    assign res_err_o   = res_err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_binary_frame_loader.sv
// Randomised self-checking bench for binary_frame_loader with a stubbed 2-output network.
module tb_binary_frame_loader;
    import mtncl_net_pkg::*;

    localparam int unsigned THR = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_last;
    logic [N_BITS-1:0] net_in;
    logic [N_OUT-1:0]  net_out;
    logic              res_valid;
    logic              res_ready;
    logic [N_OUT-1:0]  res_bits;
    logic              res_err;
    logic [15:0]       frame_cnt;

    logic              pix_valid4;
    logic              pix_ready4;
    logic [N_BITS-1:0] net_in4;
    logic [N_OUT-1:0]  net_out4;
    logic              res_valid4;
    logic              res_ready4;
    logic [N_OUT-1:0]  res_bits4;
    logic              res_err4;
    logic [15:0]       frame_cnt4;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt;
    int          pix [64];
    bit          lst [64];
    int          plen;

    always #5 clk = ~clk;

    assign net_out  = {net_in[0] ^ net_in[1], net_in[0] & net_in[1]};
    assign net_out4 = {net_in4[0] ^ net_in4[1], net_in4[0] & net_in4[1]};

    binary_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid_i (pix_valid),
        .pix_ready_o (pix_ready),
        .pix_data_i  (pix_data),
        .pix_last_i  (pix_last),
        .net_in_o    (net_in),
        .net_out_i   (net_out),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_bits_o  (res_bits),
        .res_err_o   (res_err),
        .frame_cnt_o (frame_cnt)
    );

    binary_frame_loader #(
        .EVAL_CYCLES (4)
    ) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid_i (pix_valid4),
        .pix_ready_o (pix_ready4),
        .pix_data_i  (pix_data),
        .pix_last_i  (pix_last),
        .net_in_o    (net_in4),
        .net_out_i   (net_out4),
        .res_valid_o (res_valid4),
        .res_ready_i (res_ready4),
        .res_bits_o  (res_bits4),
        .res_err_o   (res_err4),
        .frame_cnt_o (frame_cnt4)
    );

    // Reference: pixel k of the frame maps to bit k, unsent bits stay zero.
    function automatic logic [N_BITS-1:0] model_vec();
        logic [N_BITS-1:0] v = '0;
        for (int k = 0; k < plen; k++) v[k] = (pix[k] >= THR);
        return v;
    endfunction

    function automatic logic model_err();
        return !(plen == N_BITS && lst[plen-1]);
    endfunction

    function automatic logic [1:0] model_net(input logic [N_BITS-1:0] v);
        return {v[0] ^ v[1], v[0] & v[1]};
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < 64; k++) begin
            pix[k] = 0;
            lst[k] = 1'b0;
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < plen; k++) begin
            int t = 0;
            pix_data  = pix[k][PIX_W-1:0];
            pix_last  = lst[k];
            pix_valid = 1'b1;
            while (!pix_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                n_vec++;
                n_err++;
                $display("FAIL pix_ready_timeout: pixel %0d never accepted", k);
            end
            @(posedge clk);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Waits for the result, checks it against the model, holds off res_ready for
    // `hold` cycles, then completes the handshake.
    task automatic wait_result(input int hold, output logic [N_BITS-1:0] got_vec);
        logic [N_BITS-1:0] ev = model_vec();
        logic              ee = model_err();
        logic [1:0]        eb = model_net(ev);
        int                lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got_vec = net_in;
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, want 1", lat);
        end
        n_vec++;
        if (res_bits !== eb || res_err !== ee) begin
            n_err++;
            $display("FAIL result: bits=%b err=%b, want bits=%b err=%b", res_bits, res_err, eb, ee);
        end
        n_vec++;
        if (net_in !== ev) begin
            n_err++;
            $display("FAIL net_in: got %h, want %h", net_in, ev);
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            n_vec++;
            if (res_valid !== 1'b1 || pix_ready !== 1'b0 || res_bits !== eb || net_in !== ev) begin
                n_err++;
                $display("FAIL hold_stable: cycle %0d valid=%b ready=%b bits=%b net_in=%h", c,
                         res_valid, pix_ready, res_bits, net_in);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt++;
        n_vec++;
        if (frame_cnt !== exp_cnt || res_valid !== 1'b0 || pix_ready !== 1'b1 || net_in !== '0) begin
            n_err++;
            $display("FAIL handshake: cnt=%0d valid=%b ready=%b net_in=%h, want cnt=%0d 0 1 0",
                     frame_cnt, res_valid, pix_ready, net_in, exp_cnt);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (pix_ready !== 1'b1 || net_in !== '0 || res_valid !== 1'b0 || res_bits !== '0 ||
            res_err !== 1'b0 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b net_in=%h valid=%b bits=%b err=%b cnt=%0d",
                     pix_ready, net_in, res_valid, res_bits, res_err, frame_cnt);
        end
    endtask

    task automatic test_checkerboard();
        logic [N_BITS-1:0] got;
        clear_frame();
        plen = N_BITS;
        for (int k = 0; k < plen; k++) pix[k] = (k % 2 == 0) ? 255 : 0;
        lst[N_BITS-1] = 1'b1;
        send_frame();
        wait_result(0, got);
        n_vec++;
        if (got !== 49'h1_5555_5555_5555) begin
            n_err++;
            $display("FAIL checkerboard_vec: got %h, want 1555555555555", got);
        end
    endtask

    task automatic test_threshold();
        logic [N_BITS-1:0] got;
        clear_frame();
        plen = N_BITS;
        pix[0] = 127;
        pix[1] = 128;
        pix[2] = 129;
        lst[N_BITS-1] = 1'b1;
        send_frame();
        wait_result(0, got);
        n_vec++;
        if (got[2:0] !== 3'b110) begin
            n_err++;
            $display("FAIL threshold: got %b, want 110", got[2:0]);
        end
    endtask

    task automatic test_early_last();
        logic [N_BITS-1:0] got;
        clear_frame();
        plen = 10;
        for (int k = 0; k < plen; k++) pix[k] = 255;
        lst[9] = 1'b1;
        send_frame();
        wait_result(0, got);
        n_vec++;
        if (got !== 49'h3FF) begin
            n_err++;
            $display("FAIL early_last_vec: got %h, want 3ff", got);
        end
        clear_frame();
        plen = N_BITS;
        for (int k = 0; k < plen; k++) pix[k] = $urandom_range(0, 255);
        lst[N_BITS-1] = 1'b1;
        send_frame();
        wait_result(0, got);
    endtask

    task automatic test_missing_last();
        logic [N_BITS-1:0] got;
        clear_frame();
        plen = N_BITS;
        for (int k = 1; k < plen; k++) pix[k] = $urandom_range(0, 255);
        send_frame();
        // Pixel 50 is presented while the loader is busy; it must wait for the next frame.
        pix_data  = 8'd255;
        pix_last  = 1'b0;
        pix_valid = 1'b1;
        wait_result(3, got);
        clear_frame();
        plen = N_BITS;
        pix[0] = 255;
        for (int k = 1; k < plen; k++) pix[k] = $urandom_range(0, 255);
        lst[N_BITS-1] = 1'b1;
        send_frame();
        wait_result(0, got);
        n_vec++;
        if (got[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pixel50_bit0: got %b, want 1", got[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [N_BITS-1:0] got;
        clear_frame();
        plen = N_BITS;
        for (int k = 0; k < plen; k++) pix[k] = $urandom_range(0, 255);
        lst[N_BITS-1] = 1'b1;
        send_frame();
        wait_result(20, got);
    endtask

    task automatic test_reset_mid();
        logic [N_BITS-1:0] got;
        int                seen = 0;
        clear_frame();
        plen = 29;
        for (int k = 0; k < plen; k++) pix[k] = 255;
        send_frame();
        pix_data  = 8'd255;
        pix_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        n_vec++;
        if (pix_ready !== 1'b1 || net_in !== '0 || res_valid !== 1'b0 || res_bits !== '0 ||
            res_err !== 1'b0 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: ready=%b net_in=%h valid=%b bits=%b err=%b cnt=%0d",
                     pix_ready, net_in, res_valid, res_bits, res_err, frame_cnt);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_result: res_valid seen %0d cycles, want 0", seen);
        end
        test_checkerboard();
    endtask

    task automatic test_random();
        logic [N_BITS-1:0] got;
        for (int f = 0; f < 12; f++) begin
            clear_frame();
            plen = $urandom_range(1, N_BITS);
            for (int k = 0; k < plen; k++)
                pix[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(126, 130) : $urandom_range(0, 255);
            if (plen < N_BITS || $urandom_range(0, 1) == 1) lst[plen-1] = 1'b1;
            send_frame();
            wait_result($urandom_range(0, 4), got);
        end
    endtask

    task automatic test_eval4();
        int lat = 0;
        for (int k = 0; k < N_BITS; k++) begin
            pix_data   = (k % 2 == 0) ? 8'd200 : 8'd10;
            pix_last   = (k == N_BITS - 1);
            pix_valid4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        pix_valid4 = 1'b0;
        pix_last   = 1'b0;
        while (!res_valid4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL eval4_latency: got %0d cycles, want 4", lat);
        end
        n_vec++;
        if (res_bits4 !== 2'b10 || res_err4 !== 1'b0 || net_in4 !== 49'h1_5555_5555_5555) begin
            n_err++;
            $display("FAIL eval4_result: bits=%b err=%b net_in=%h, want 10 0 1555555555555",
                     res_bits4, res_err4, net_in4);
        end
        res_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready4 = 1'b0;
        n_vec++;
        if (frame_cnt4 !== 16'd1 || pix_ready4 !== 1'b1) begin
            n_err++;
            $display("FAIL eval4_handshake: cnt=%0d ready=%b, want 1 1", frame_cnt4, pix_ready4);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        pix_last   = 1'b0;
        res_ready  = 1'b0;
        pix_valid4 = 1'b0;
        res_ready4 = 1'b0;
        exp_cnt    = 16'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_checkerboard();
        test_threshold();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_eval4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
